// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse-train generator.
//   state_t : FSM state encoding (IDLE/HIGH/LOW); 2'd3 is unused and
//             recovers to IDLE.
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times one HIGH or LOW phase.
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset (count cleared to 0)
//   load     : load load_val this cycle (has priority over counting)
//   load_val : value loaded into the counter
//   zero     : counter currently holds 0
// The counter stops at 0 instead of wrapping.
module phase_timer #(
  parameter int unsigned TMR_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             zero
);

  logic [TMR_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - TMR_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Pulse-train source: on a one-cycle start, emits n_pulses pulses, each
// HIGH_CYCLES high followed by LOW_CYCLES low, then strobes done.
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   start    : one-cycle train request, sampled only in IDLE
//   n_pulses : pulse count, sampled with an accepted start (0 => done only)
//   abort    : synchronous cancel of a running train (no done)
//   out      : registered pulse-train output
//   busy     : registered, high while a train is in progress
//   done     : registered one-cycle completion strobe
module pulse_train_gen
  import pulse_pkg::*;
#(
  parameter int unsigned HIGH_CYCLES = 62500000,
  parameter int unsigned LOW_CYCLES  = 62500000,
  parameter int unsigned TMR_W       = 26,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_pulses,
  input  logic             abort,
  output logic             out,
  output logic             busy,
  output logic             done
);

  localparam logic [TMR_W-1:0] HIGH_LD = TMR_W'(HIGH_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOW_LD  = TMR_W'(LOW_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] remaining_nxt;
  logic [CNT_W-1:0] rem_dec;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_zero;
  logic             done_nxt;

  phase_timer #(
    .TMR_W(TMR_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_val),
    .zero    (tmr_zero)
  );

  assign rem_dec = remaining - CNT_W'(1);

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    tmr_load      = 1'b0;
    tmr_val       = '0;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (n_pulses != '0) begin
            remaining_nxt = n_pulses;
            tmr_load      = 1'b1;
            tmr_val       = HIGH_LD;
            state_nxt     = HIGH;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      HIGH: begin
        if (abort) begin
          remaining_nxt = '0;
          tmr_load      = 1'b1;
          state_nxt     = IDLE;
        end else if (tmr_zero) begin
          tmr_load  = 1'b1;
          tmr_val   = LOW_LD;
          state_nxt = LOW;
        end
      end
      LOW: begin
        if (abort) begin
          remaining_nxt = '0;
          tmr_load      = 1'b1;
          state_nxt     = IDLE;
        end else if (tmr_zero) begin
          remaining_nxt = rem_dec;
          if (rem_dec != '0) begin
            tmr_load  = 1'b1;
            tmr_val   = HIGH_LD;
            state_nxt = HIGH;
          end else begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        remaining_nxt = '0;
        tmr_load      = 1'b1;
        state_nxt     = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state itself, keeping out/busy glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      remaining <= '0;
      out       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      out       <= (state_nxt == HIGH);
      busy      <= (state_nxt != IDLE);
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen (H=3, L=2, CNT_W=4).
// Stimulus pushes the expected output changes {out,busy,done} with their
// cycle numbers; a monitor pops one entry whenever the outputs change.
module tb_pulse_train_gen;

  typedef struct {
    int         cyc;
    logic [2:0] vec;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] n_pulses;
  logic       abort;
  logic       out;
  logic       busy;
  logic       done;

  int  cyc;
  int  errors;
  int  checks;
  int  rises;
  ev_t q[$];

  pulse_train_gen #(
    .HIGH_CYCLES(3),
    .LOW_CYCLES (2),
    .TMR_W      (2),
    .CNT_W      (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .n_pulses(n_pulses),
    .abort   (abort),
    .out     (out),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [2:0] v);
    ev_t e;
    e.cyc = c;
    e.vec = v;
    q.push_back(e);
  endtask

  // Train of n pulses with start accepted in cycle t; when chained, a new
  // start is accepted in the done cycle so outputs never return to 000.
  task automatic push_train(input int t, input int n, input bit chained);
    for (int k = 0; k < n; k++) begin
      push(t + 1 + 5 * k, 3'b110);
      push(t + 4 + 5 * k, 3'b010);
    end
    push(t + 5 * n + 1, 3'b001);
    if (!chained) push(t + 5 * n + 2, 3'b000);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [2:0] prev;
    logic [2:0] cur;
    ev_t        e;
    prev = 3'b000;
    forever begin
      @(negedge clk);
      cur = {out, busy, done};
      if (cur !== prev) begin
        if (!prev[2] && cur[2]) rises++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, cur);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.vec !== cur) begin
            errors++;
            $display("FAIL event cyc=%0d got=%b required cyc=%0d vec=%b",
                     cyc, cur, e.cyc, e.vec);
          end
        end
      end
      prev = cur;
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; start is high for the current cycle only.
  task automatic start_at(input logic [3:0] n, input logic ab);
    start    = 1'b1;
    n_pulses = n;
    abort    = ab;
    cyc_wait(1);
    start    = 1'b0;
    abort    = 1'b0;
    n_pulses = 4'hF;
  endtask

  initial begin
    int t;
    errors   = 0;
    checks   = 0;
    rises    = 0;
    start    = 1'b0;
    abort    = 1'b0;
    n_pulses = 4'h0;
    rst      = 1'b1;
    fork
      monitor();
    join_none
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    cyc_wait(1);
    chk("reset_outputs", int'({out, busy, done}), 0);
    cyc_wait(10);

    // three pulses, with rising-edge count
    rises = 0;
    t = cyc;
    push_train(t, 3, 1'b0);
    start_at(4'd3, 1'b0);
    cyc_wait(20);
    chk("rise_count_3", rises, 3);

    // zero pulses: done only
    t = cyc;
    push(t + 1, 3'b001);
    push(t + 2, 3'b000);
    start_at(4'd0, 1'b0);
    cyc_wait(5);

    // two pulses with ignored starts at t+2 and t+9, chained start in done cycle
    t = cyc;
    push_train(t, 2, 1'b1);
    start_at(4'd2, 1'b0);
    cyc_wait(1);
    start = 1'b1; n_pulses = 4'd5;
    cyc_wait(1);
    start = 1'b0;
    cyc_wait(6);
    start = 1'b1; n_pulses = 4'd7;
    cyc_wait(1);
    start = 1'b0;
    cyc_wait(1);
    chk("done_cycle_for_chain", cyc, t + 11);
    push_train(cyc, 1, 1'b0);
    start_at(4'd1, 1'b0);
    cyc_wait(10);

    // abort in the second HIGH phase
    t = cyc;
    push(t + 1, 3'b110);
    push(t + 4, 3'b010);
    push(t + 6, 3'b110);
    push(t + 8, 3'b000);
    start_at(4'd2, 1'b0);
    cyc_wait(6);
    abort = 1'b1;
    cyc_wait(1);
    abort = 1'b0;
    cyc_wait(6);
    push_train(cyc, 1, 1'b0);
    start_at(4'd1, 1'b0);
    cyc_wait(8);

    // abort together with start in IDLE: start wins
    push_train(cyc, 2, 1'b0);
    start_at(4'd2, 1'b1);
    cyc_wait(14);

    // asynchronous reset in the middle of the first pulse
    t = cyc;
    push(t + 1, 3'b110);
    push(t + 3, 3'b000);
    start_at(4'd3, 1'b0);
    cyc_wait(1);
    #6 rst = 1'b0;
    #1;
    chk("async_rst_out", int'(out), 0);
    chk("async_rst_busy", int'(busy), 0);
    #10 rst = 1'b1;
    cyc_wait(1);
    cyc_wait(8);
    push_train(cyc, 1, 1'b0);
    start_at(4'd1, 1'b0);
    cyc_wait(8);

    // maximum count
    rises = 0;
    push_train(cyc, 15, 1'b0);
    start_at(4'd15, 1'b0);
    cyc_wait(82);
    chk("rise_count_15", rises, 15);

    chk("events_left", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
